// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// error causes and the request legality check used at accept time.
package lsu_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_FUNCT3   = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } lsu_err_t;

    // An unknown funct3 is reported ahead of misalignment, since size is meaningless then.
    function automatic lsu_err_t check_request(input logic       wr,
                                               input logic [2:0] bits,
                                               input logic [1:0] off);
        logic     legal;
        lsu_err_t cause;
        legal = 1'b0;
        cause = ERR_NONE;
        if (wr) begin
            case (bits)
                F3_SB, F3_SH, F3_SW: legal = 1'b1;
                default:             legal = 1'b0;
            endcase
        end else begin
            case (bits)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
                default:                             legal = 1'b0;
            endcase
        end
        if (!legal) begin
            cause = ERR_FUNCT3;
        end else if ((bits[1:0] == 2'b01 && off[0]) ||
                     (bits[1:0] == 2'b10 && off != 2'b00)) begin
            cause = ERR_MISALIGN;
        end
        return cause;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: builds store mask/data lanes and extracts and extends
// load data from a memory word, given funct3 and the address offset.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  bits,
    input  logic [1:0]  off,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Sub-word stores replicate the datum across the word so any lane picks it up.
    always_comb begin
        wmask = 4'b1111;
        wdata = st_data;
        case (bits)
            F3_SB: begin
                wmask = 4'b0001 << off;
                wdata = {4{st_data[7:0]}};
            end
            F3_SH: begin
                wmask = 4'b0011 << off;
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    always_comb begin
        shifted = ld_word >> {off, 3'b000};
        ld_data = 32'd0;
        case (bits)
            F3_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   ld_data = shifted;
            F3_LBU:  ld_data = {24'd0, shifted[7:0]};
            F3_LHU:  ld_data = {16'd0, shifted[15:0]};
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one op from the core, runs a
// valid/ready transaction on data memory and returns one response pulse.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [2:0]        req_bits,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_t        state_q;
    lsu_state_t        state_d;
    logic              wr_q;
    logic [2:0]        bits_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    lsu_err_t          cause_q;
    logic [31:0]       rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;
    logic              accept;
    lsu_err_t          req_cause;
    logic [3:0]        lane_mask;
    logic [31:0]       lane_wdata;
    logic [31:0]       ld_data;

    assign accept    = req_valid && (state_q == IDLE);
    assign req_cause = check_request(req_wr, req_bits, req_addr[1:0]);

    // Saturating, so a handshake that beats the timeout cannot let the count wrap.
    assign cnt_inc     = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

    lsu_align u_align (
        .bits    (bits_q),
        .off     (addr_q[1:0]),
        .st_data (wdata_q),
        .ld_word (mem_rsp_rdata),
        .wmask   (lane_mask),
        .wdata   (lane_wdata),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory progress always wins over a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (req_cause != ERR_NONE) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else if (timeout_hit) begin
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (mem_rsp_valid || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (state_q == IDLE);
        mem_req_valid = (state_q == ISSUE);
        mem_wen       = (state_q == ISSUE) && wr_q;
        mem_wmask     = ((state_q == ISSUE) && wr_q) ? lane_mask : 4'b0000;
        mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata     = lane_wdata;
        resp_valid    = (state_q == RESP);
        resp_err      = (state_q == RESP) && (cause_q != ERR_NONE);
        resp_rdata    = (state_q == RESP) ? rdata_q : 32'd0;
    end

    // Captured request, response data and timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= 1'b0;
            bits_q  <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            cause_q <= ERR_NONE;
            rdata_q <= 32'd0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        wr_q    <= req_wr;
                        bits_q  <= req_bits;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cause_q <= req_cause;
                        rdata_q <= 32'd0;
                        cnt_q   <= '0;
                    end
                end
                ISSUE: begin
                    cnt_q <= cnt_inc;
                    if (!mem_req_ready && timeout_hit) begin
                        cause_q <= ERR_TIMEOUT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_inc;
                    if (mem_rsp_valid) begin
                        rdata_q <= wr_q ? 32'd0 : ld_data;
                    end else if (timeout_hit) begin
                        cause_q <= ERR_TIMEOUT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: the driver queues expected responses, a
// separate monitor pops and compares them whenever resp_valid is seen.
module tb_lsu_ctrl;

    localparam int NEVER = 1000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acceptCyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_bits;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t respQ[$];

    lsu_ctrl #(.TIMEOUT(8), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wr        (req_wr),
        .req_bits      (req_bits),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every response must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && resp_valid) begin
                if (respQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedResp: got resp_valid=1, expected no response (cycle %0d)", cyc);
                end else begin
                    e = respQ.pop_front();
                    checkOutput("respRdata", resp_rdata, e.rdata);
                    checkOutput("respErr", {31'd0, resp_err}, {31'd0, e.err});
                    checkOutput("respLatency", 32'(cyc - e.acceptCyc), 32'(e.lat));
                end
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [2:0] bits, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRdata,
                                 input logic expErr, input int expLat);
        exp_t e;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        checkOutput("reqReady", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_bits  = bits;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        e.rdata     = expRdata;
        e.err       = expErr;
        e.lat       = expLat;
        e.acceptCyc = cyc - 1;
        respQ.push_back(e);
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_bits  = 3'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
    endtask

    // Holds mem_req_ready low for d ISSUE cycles and mem_rsp_valid low for r WAIT cycles.
    task automatic serveMem(input int d, input int r, input logic [31:0] word, input logic wen,
                            input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] wdata);
        if (d == NEVER) begin
            @(negedge clk);
            checkOutput("memReqValid", {31'd0, mem_req_valid}, 32'd1);
            return;
        end
        for (int i = 0; i <= d; i++) begin
            @(negedge clk);
            checkOutput("memReqValid", {31'd0, mem_req_valid}, 32'd1);
            checkOutput("memAddr", mem_addr, addr);
            checkOutput("memWen", {31'd0, mem_wen}, {31'd0, wen});
            checkOutput("memWmask", {28'd0, mem_wmask}, {28'd0, mask});
            checkOutput("memWdata", mem_wdata, wdata);
            if (i == d) mem_req_ready = 1'b1;
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        checkOutput("memReqDrop", {31'd0, mem_req_valid}, 32'd0);
        if (r == NEVER) return;
        for (int j = 0; j <= r; j++) begin
            if (j > 0) @(negedge clk);
            if (j == r) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = word;
            end
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'd0;
    endtask

    task automatic waitResp();
        for (int i = 0; i < 40; i++) begin
            if (respQ.size() == 0) break;
            @(negedge clk);
        end
        if (respQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL respMissing: got no resp_valid within 40 cycles, expected %0d pending", respQ.size());
            respQ.delete();
        end
    endtask

    task automatic runOp(input logic wr, input logic [2:0] bits, input logic [31:0] addr,
                         input logic [31:0] wdata, input int d, input int r, input logic [31:0] word,
                         input logic [3:0] expMask, input logic [31:0] expWdata,
                         input logic [31:0] expRdata, input logic expErr, input int expLat);
        applyStimulus(wr, bits, addr, wdata, expRdata, expErr, expLat);
        if (expLat == 1) begin
            @(negedge clk);
            checkOutput("noMemReq", {31'd0, mem_req_valid}, 32'd0);
            @(negedge clk);
            checkOutput("noMemReqAfter", {31'd0, mem_req_valid}, 32'd0);
        end else begin
            serveMem(d, r, word, wr, addr & 32'hFFFF_FFFC, expMask, expWdata);
        end
        waitResp();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 100000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_bits = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("rstReqReady", {31'd0, req_ready}, 32'd1);
        checkOutput("rstRespValid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rstMemReqValid", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("rstMemAddr", mem_addr, 32'd0);
        checkOutput("rstMemWdata", mem_wdata, 32'd0);
        checkOutput("rstMemWmask", {28'd0, mem_wmask}, 32'd0);
        checkOutput("rstRespRdata", resp_rdata, 32'd0);
        rst = 1'b1;

        //    wr  bits    addr          wdata         d      r      word          mask     wdata         rdata         err   lat
        runOp(0, 3'b000, 32'h8000_0003, 32'h0,        0,     0,     32'h80FF_1234, 4'b0000, 32'h0,        32'hFFFF_FF80, 0,    3);
        runOp(1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 0,    0,     32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0,    3);
        runOp(0, 3'b010, 32'h8000_0006, 32'h0,        0,     0,     32'h0,         4'b0000, 32'h0,        32'h0,        1,    1);
        runOp(0, 3'b101, 32'h8000_0001, 32'h0,        0,     0,     32'h0,         4'b0000, 32'h0,        32'h0,        1,    1);
        runOp(0, 3'b010, 32'h8000_0010, 32'h0,        5,     0,     32'h1234_5678, 4'b0000, 32'h0,        32'h1234_5678, 0,   8);
        runOp(0, 3'b100, 32'h8000_0021, 32'h0,        0,     0,     32'h1122_9A33, 4'b0000, 32'h0,        32'h0000_009A, 0,   3);
        runOp(0, 3'b001, 32'h8000_0002, 32'h0,        0,     2,     32'h8001_7FFF, 4'b0000, 32'h0,        32'hFFFF_8001, 0,   5);
        runOp(0, 3'b101, 32'h8000_0002, 32'h0,        1,     0,     32'h8001_7FFF, 4'b0000, 32'h0,        32'h0000_8001, 0,   4);
        runOp(1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 0,    0,     32'h0,         4'b0010, 32'hABAB_ABAB, 32'h0,        0,    3);
        runOp(1, 3'b010, 32'h8000_0004, 32'hCAFE_F00D, 2,    1,     32'h0,         4'b1111, 32'hCAFE_F00D, 32'h0,        0,    6);
        runOp(0, 3'b011, 32'h8000_0000, 32'h0,        0,     0,     32'h0,         4'b0000, 32'h0,        32'h0,        1,    1);
        runOp(1, 3'b100, 32'h8000_0000, 32'h0,        0,     0,     32'h0,         4'b0000, 32'h0,        32'h0,        1,    1);
        runOp(1, 3'b001, 32'h8000_0003, 32'h0,        0,     0,     32'h0,         4'b0000, 32'h0,        32'h0,        1,    1);

        $display("[TB] timeout in WAIT, then a late response");
        runOp(0, 3'b010, 32'h8000_0040, 32'h0,        0,     NEVER, 32'h0,         4'b0000, 32'h0,        32'h0,        1,    9);
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("lateRspIgnored", {31'd0, resp_valid}, 32'd0);
        end
        runOp(0, 3'b000, 32'h8000_0000, 32'h0,        0,     0,     32'h1234_567F, 4'b0000, 32'h0,        32'h0000_007F, 0,   3);

        $display("[TB] timeout in ISSUE and handshake/timeout ties");
        runOp(1, 3'b010, 32'h8000_0044, 32'h1111_2222, NEVER, 0,    32'h0,         4'b1111, 32'h1111_2222, 32'h0,        1,    9);
        checkOutput("memReqAfterTimeout", {31'd0, mem_req_valid}, 32'd0);
        runOp(0, 3'b010, 32'h8000_0048, 32'h0,        7,     0,     32'hA5A5_A5A5, 4'b0000, 32'h0,        32'hA5A5_A5A5, 0,   10);

        $display("[TB] asynchronous reset while waiting for memory");
        applyStimulus(0, 3'b010, 32'h8000_0080, 32'h0, 32'h0, 0, 3);
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("asyncRstReqReady", {31'd0, req_ready}, 32'd1);
        checkOutput("asyncRstMemReqValid", {31'd0, mem_req_valid}, 32'd0);
        checkOutput("asyncRstRespValid", {31'd0, resp_valid}, 32'd0);
        checkOutput("asyncRstMemAddr", mem_addr, 32'd0);
        respQ.delete();
        @(negedge clk);
        rst = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("noRespAfterReset", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        runOp(0, 3'b000, 32'h8000_0002, 32'h0,        0,     0,     32'h00FE_0000, 4'b0000, 32'h0,        32'hFFFF_FFFE, 0,   3);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit sitting directly downstream of the ALU in the RV32 core.
- Takes the ALU result as the effective address, plus the decoder's Mem_wr / Mem_bits and the rs2 value.
- Runs a valid/ready transaction against data memory, with byte masking, misalignment detection and a response timeout.
- Returns aligned, sign/zero-extended load data to register writeback.
- Lets the core stall on multi-cycle memory instead of assuming single-cycle MEM.

Parameters:
- TIMEOUT, 255: maximum cycles spent in ISSUE+WAIT before aborting with error; width of counter = clog2(TIMEOUT+1).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  core clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  core presents a memory op.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_wr  in  1  1=store, 0=load (decoder Mem_wr).
- req_bits  in  3  funct3 (decoder Mem_bits).
- req_addr  in  ADDR_W  effective byte address (ALU result).
- req_wdata  in  32  store data (R_rs2).
- resp_valid  out  1  one-cycle pulse, op complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid: misaligned, illegal funct3 or timeout.
- mem_req_valid  out  1  request to data memory.
- mem_req_ready  in  1  memory accepts request.
- mem_wen  out  1  write enable.
- mem_addr  out  ADDR_W  word address, req_addr with [1:0] forced to 0.
- mem_wdata  out  32  store data shifted into byte lanes.
- mem_wmask  out  4  byte-lane enables; 0 for loads.
- mem_rsp_valid  in  1  read data or write ack.
- mem_rsp_rdata  in  32  word read data.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset (rst=0, async) -> IDLE.
- Reset values:
  - All outputs 0, except req_ready=1.
  - Captured request registers 0.
  - Timeout counter 0.
- Accept rule (IDLE):
  - Request accepted when req_valid & req_ready; req_wr, req_bits, req_addr and req_wdata are registered.
  - Inputs are ignored in every other state.
- Legality checks on the captured request:
  - Loads: bits ∈ {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Stores: bits ∈ {000 SB, 001 SH, 010 SW}.
  - Halfword ops require addr[0]=0; word ops require addr[1:0]=00.
- IDLE -> RESP (err=1) on an illegal or misaligned op; no memory traffic.
- IDLE -> ISSUE otherwise.
- ISSUE:
  - mem_req_valid=1 with mem_wen, mem_addr, mem_wdata and mem_wmask held stable until mem_req_ready.
  - On handshake -> WAIT.
  - mem_rsp_valid is ignored in ISSUE.
- WAIT: on mem_rsp_valid, capture the extended data -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle -> IDLE.
  - req_ready stays 0 in RESP, so there is no back-to-back accept in the same cycle.
- Store lane formation (off = addr[1:0]):
  - SB: wmask = 0001<<off; wdata = {4{byte0}}.
  - SH: wmask = 0011<<off; wdata = {2{half0}}.
  - SW: wmask = 1111; wdata unchanged.
- Load extraction:
  - Byte = rdata >> (8*off).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Timeout:
  - Counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT.
  - When the counter == TIMEOUT and the transition has not happened -> RESP with err=1, rdata=0; mem_req_valid drops.
  - A late mem_rsp_valid arriving afterwards in IDLE is ignored.
- Simultaneous events: a handshake and the timeout in the same cycle resolve as handshake wins (-> WAIT), and the same applies to rsp vs timeout in WAIT.
- Minimum latency: accept at cycle N, resp_valid at cycle N+3 (mem_req_ready=1 at N+1, mem_rsp_valid=1 at N+2).
- Reset mid-operation: immediate return to IDLE; outputs take their reset values asynchronously; no response is ever produced for the aborted op.

Decomposition:
- Shared package holds:
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - State enum: IDLE, ISSUE, WAIT, RESP.
  - Error-cause constants.
- One sub-module, lsu_align: purely combinational; produces wmask/wdata lanes and load extraction/extension from bits, off and data.
- The FSM and counter stay in lsu_ctrl.

Test Plan:
- LB, addr=0x80000003, mem word 0x80FF1234 returned next cycle -> mem_addr=0x80000000, wmask=0000, resp_rdata=0xFFFFFF80, err=0, resp_valid 3 cycles after accept.
- SH, addr=0x80000002, wdata=0x0000BEEF -> mem_wen=1, wmask=1100, mem_wdata=0xBEEFBEEF, resp_rdata=0, err=0.
- LW, addr=0x80000006 -> no mem_req_valid ever, resp_valid next cycle with err=1; LHU at 0x80000001 -> same.
- LW with mem_req_ready held 0 for 5 cycles -> address/valid stable throughout; LBU of byte 0x9A -> resp_rdata=0x0000009A.
- TIMEOUT=8, mem_rsp_valid never asserted -> resp_valid with err=1 exactly 8 cycles after ISSUE entry; a following request is accepted normally.
- rst driven to 0 asynchronously while in WAIT -> req_ready=1 and mem_req_valid=0 immediately; no resp_valid after release.
